// File: rtl/gate_input_debouncer.sv
// gate_input_debouncer: synchronises and debounces raw switch/pin levels per channel.
// Each channel is one gate_input_debouncer_lane instance. The lane has a SYNC_STAGES-deep
// synchroniser and a persistence counter. It produces a registered clean level plus
// one-cycle rise/fall pulses.
// Optional build macro GATE_DEBOUNCE_GLITCH_CNT_EN adds a saturating 8-bit count of
// rejected glitches per channel on the glitch_cnt port.

module gate_input_debouncer_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  , output logic [7:0] glitch_cnt
`endif
);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser chain; the raw pin feeds nothing but the first stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end

  // Persistence counter: accept a new level only after CNT_MAX consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        dout <= s;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  // Count rejected glitches: a partial count aborted because the input returned; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      glitch_cnt <= 8'h00;
    else if (s == dout && cnt != '0 && glitch_cnt != 8'hFF)
      glitch_cnt <= glitch_cnt + 8'h01;
  end
`endif

endmodule

module gate_input_debouncer #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din_raw,
  output logic [WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]   rise,
  output logic [WIDTH-1:0]   fall
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  , output logic [8*WIDTH-1:0] glitch_cnt
`endif
);

  // One fully independent lane per channel.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gate_input_debouncer_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_MAX    (CNT_MAX)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din_raw[i]),
      .dout      (dout[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
      , .glitch_cnt(glitch_cnt[8*i +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Scoreboard bench for gate_input_debouncer (WIDTH=2, SYNC_STAGES=2, CNT_MAX=4).
// Stimulus pushes one expected output record per clock; the monitor pops and compares
// just after each rising edge.
module tb_gate_input_debouncer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] din_raw;
  logic [1:0] dout, rise, fall;
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch_cnt;
`endif

  gate_input_debouncer #(.WIDTH(2), .SYNC_STAGES(2), .CNT_MAX(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_raw(din_raw),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall)
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  d, r, f;
    logic        gc_chk;
    logic [15:0] gc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare the outputs after each edge against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dout", {14'd0, dout}, {14'd0, e.d});
        chk("rise", {14'd0, rise}, {14'd0, e.r});
        chk("fall", {14'd0, fall}, {14'd0, e.f});
`ifdef GATE_DEBOUNCE_GLITCH_CNT_EN
        if (e.gc_chk) chk("glitch_cnt", glitch_cnt, e.gc);
`endif
      end
    end
  end

  // One clock: drive din at the falling edge, queue the outputs expected after the next rise.
  task automatic cyc(input logic [1:0] din, input logic [1:0] ed, input logic [1:0] er,
                     input logic [1:0] ef);
    exp_t e;
    din_raw = din;
    e.d = ed; e.r = er; e.f = ef; e.gc_chk = 1'b0; e.gc = 16'h0;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic [1:0] din, input int n, input logic [1:0] ed);
    for (int k = 0; k < n; k++) cyc(din, ed, 2'b00, 2'b00);
  endtask

  // New level held: old dout for 5 edges, new dout plus pulse on the 6th.
  task automatic change(input logic [1:0] din, input logic [1:0] od, input logic [1:0] nd);
    hold(din, 5, od);
    cyc(din, nd, nd & ~od, od & ~nd);
  endtask

  task automatic gck(input logic [1:0] din, input logic [1:0] ed, input logic [15:0] gc);
    exp_t e;
    din_raw = din;
    e.d = ed; e.r = 2'b00; e.f = 2'b00; e.gc_chk = 1'b1; e.gc = gc;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    din_raw = 2'b00;
    @(negedge clk);
    // 1: reset state and quiet input after release
    hold(2'b00, 2, 2'b00);
    rst_n = 1'b1;
    hold(2'b00, 10, 2'b00);
    // 3: 3-cycle pulse on bit 0 is rejected and counted
    hold(2'b01, 3, 2'b00);
    hold(2'b00, 6, 2'b00);
    gck(2'b00, 2'b00, 16'h0001);
    // 2: bit 0 rises on the 6th edge, bit 1 untouched
    change(2'b01, 2'b00, 2'b01);
    hold(2'b01, 3, 2'b01);
    // 4: bit 1 joins, then both fall together
    change(2'b11, 2'b01, 2'b11);
    hold(2'b11, 3, 2'b11);
    change(2'b00, 2'b11, 2'b00);
    hold(2'b00, 3, 2'b00);
    // 5: reset in the middle of a pending 0->1 on bit 0 (bit 1 already high)
    change(2'b10, 2'b00, 2'b10);
    hold(2'b11, 4, 2'b10);
    rst_n = 1'b0;
    din_raw = 2'b00;
    #1;
    chk("async_reset_dout", {14'd0, dout}, 16'h0000);
    chk("async_reset_rise", {14'd0, rise}, 16'h0000);
    @(negedge clk);
    hold(2'b00, 2, 2'b00);
    rst_n = 1'b1;
    hold(2'b00, 10, 2'b00);
    gck(2'b00, 2'b00, 16'h0000);
    // 7: input high across reset release rises once after standard latency
    rst_n = 1'b0;
    hold(2'b11, 2, 2'b00);
    rst_n = 1'b1;
    change(2'b11, 2'b00, 2'b11);
    hold(2'b11, 3, 2'b11);
    change(2'b00, 2'b11, 2'b00);
    hold(2'b00, 3, 2'b00);
    // 6: 300 one-cycle glitches on bit 1; counter saturates, bit 0 stays 0
    for (int k = 0; k < 200; k++) begin
      cyc(2'b10, 2'b00, 2'b00, 2'b00);
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
    end
    hold(2'b00, 4, 2'b00);
    gck(2'b00, 2'b00, 16'hC800);
    for (int k = 0; k < 100; k++) begin
      cyc(2'b10, 2'b00, 2'b00, 2'b00);
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
    end
    hold(2'b00, 4, 2'b00);
    gck(2'b00, 2'b00, 16'hFF00);
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
